// File: rtl/ram_arbiter_if.sv
// Client and RAM-side signal bundle for ram_arbiter; slave is the arbiter view,
// master is the clients-plus-RAM view.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  c0_req;
  logic                  c0_we;
  logic [ADDR_WIDTH-1:0] c0_addr;
  logic [DATA_WIDTH-1:0] c0_wdata;
  logic                  c0_gnt;
  logic                  c0_rvalid;
  logic [DATA_WIDTH-1:0] c0_rdata;

  logic                  c1_req;
  logic                  c1_we;
  logic [ADDR_WIDTH-1:0] c1_addr;
  logic [DATA_WIDTH-1:0] c1_wdata;
  logic                  c1_gnt;
  logic                  c1_rvalid;
  logic [DATA_WIDTH-1:0] c1_rdata;

  logic                  ram_wren;
  logic [ADDR_WIDTH-1:0] ram_wraddress;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_rdaddress;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    input  ram_q,
    output c0_gnt, c0_rvalid, c0_rdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output ram_wren, ram_wraddress, ram_data, ram_rdaddress
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    output ram_q,
    input  c0_gnt, c0_rvalid, c0_rdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  ram_wren, ram_wraddress, ram_data, ram_rdaddress
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-client round-robin arbiter in front of a simple dual-port RAM; zero-cycle grants,
// read data one cycle after grant. Ungranted clients hold their request until accepted.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  logic                  wr_prio_q, wr_prio_d;
  logic                  rd_prio_q, rd_prio_d;
  logic [1:0]            rd_owner_q, rd_owner_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic [1:0] wr_cand, rd_cand;
  logic       wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;

  always_comb begin
    wr_gnt0    = 1'b0;
    wr_gnt1    = 1'b0;
    rd_gnt0    = 1'b0;
    rd_gnt1    = 1'b0;
    wr_prio_d  = wr_prio_q;
    rd_prio_d  = rd_prio_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    wr_cand    = {bus.c1_req & bus.c1_we, bus.c0_req & bus.c0_we};
    rd_cand    = {bus.c1_req & ~bus.c1_we, bus.c0_req & ~bus.c0_we};

    // prio pointer names the client that wins a tie; grants are suppressed in reset
    if (!rst) begin
      wr_gnt0 = wr_cand[0] & (~wr_cand[1] | ~wr_prio_q);
      wr_gnt1 = wr_cand[1] & (~wr_cand[0] |  wr_prio_q);
      rd_gnt0 = rd_cand[0] & (~rd_cand[1] | ~rd_prio_q);
      rd_gnt1 = rd_cand[1] & (~rd_cand[0] |  rd_prio_q);
    end

    if (wr_gnt0) begin
      wr_prio_d = 1'b1;
      wr_addr_d = bus.c0_addr;
      wr_data_d = bus.c0_wdata;
    end else if (wr_gnt1) begin
      wr_prio_d = 1'b0;
      wr_addr_d = bus.c1_addr;
      wr_data_d = bus.c1_wdata;
    end

    if (rd_gnt0) begin
      rd_prio_d = 1'b1;
      rd_addr_d = bus.c0_addr;
    end else if (rd_gnt1) begin
      rd_prio_d = 1'b0;
      rd_addr_d = bus.c1_addr;
    end

    rd_owner_d = {rd_gnt1, rd_gnt0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prio_q  <= 1'b0;
      rd_prio_q  <= 1'b0;
      rd_owner_q <= 2'b00;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      wr_prio_q  <= wr_prio_d;
      rd_prio_q  <= rd_prio_d;
      rd_owner_q <= rd_owner_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bus.c0_gnt        = wr_gnt0 | rd_gnt0;
  assign bus.c1_gnt        = wr_gnt1 | rd_gnt1;
  assign bus.ram_wren      = wr_gnt0 | wr_gnt1;
  assign bus.ram_wraddress = wr_addr_d;
  assign bus.ram_data      = wr_data_d;
  assign bus.ram_rdaddress = rd_addr_d;

  // RAM output is registered, so one shared bus qualified per client is enough
  assign bus.c0_rvalid = rd_owner_q[0];
  assign bus.c1_rvalid = rd_owner_q[1];
  assign bus.c0_rdata  = bus.ram_q;
  assign bus.c1_rdata  = bus.ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-before-write RAM model.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [7:0] mem [16];

  ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered read port; old word is read when addresses collide
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_rdaddress];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic r0, input logic w0, input logic [3:0] a0,
                      input logic [7:0] d0, input logic r1, input logic w1,
                      input logic [3:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    rst = r;
    bus.c0_req = r0; bus.c0_we = w0; bus.c0_addr = a0; bus.c0_wdata = d0;
    bus.c1_req = r1; bus.c1_we = w1; bus.c1_addr = a1; bus.c1_wdata = d1;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst = 1'b1;
    bus.c0_req = 1'b1; bus.c0_we = 1'b1; bus.c0_addr = 4'h3; bus.c0_wdata = 8'hAA;
    bus.c1_req = 1'b1; bus.c1_we = 1'b1; bus.c1_addr = 4'h3; bus.c1_wdata = 8'h55;

    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'h3, 8'hAA, 1'b1, 1'b1, 4'h3, 8'h55);
      chk("rst_c0_gnt", bus.c0_gnt, 0);
      chk("rst_c1_gnt", bus.c1_gnt, 0);
      chk("rst_wren", bus.ram_wren, 0);
      chk("rst_c0_rvalid", bus.c0_rvalid, 0);
      chk("rst_c1_rvalid", bus.c1_rvalid, 0);
    end

    // contested writes to addr 3
    step(1'b0, 1'b1, 1'b1, 4'h3, 8'hAA, 1'b1, 1'b1, 4'h3, 8'h55);
    chk("cw1_c0_gnt", bus.c0_gnt, 1);
    chk("cw1_c1_gnt", bus.c1_gnt, 0);
    chk("cw1_wren", bus.ram_wren, 1);
    chk("cw1_wraddr", bus.ram_wraddress, 32'h3);
    chk("cw1_data", bus.ram_data, 32'hAA);
    step(1'b0, 1'b1, 1'b1, 4'h3, 8'hAA, 1'b1, 1'b1, 4'h3, 8'h55);
    chk("cw2_c0_gnt", bus.c0_gnt, 0);
    chk("cw2_c1_gnt", bus.c1_gnt, 1);
    chk("cw2_data", bus.ram_data, 32'h55);

    step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("rd3_c0_gnt", bus.c0_gnt, 1);
    chk("rd3_wren", bus.ram_wren, 0);
    chk("rd3_rdaddr", bus.ram_rdaddress, 32'h3);
    idle();
    chk("rd3_c0_rvalid", bus.c0_rvalid, 1);
    chk("rd3_c1_rvalid", bus.c1_rvalid, 0);
    chk("rd3_rdata", bus.c0_rdata, 32'h55);

    // write and read of addr 5 granted together
    step(1'b0, 1'b1, 1'b1, 4'h5, 8'h11, 1'b1, 1'b0, 4'h5, 8'h00);
    chk("par_c0_gnt", bus.c0_gnt, 1);
    chk("par_c1_gnt", bus.c1_gnt, 1);
    chk("par_wren", bus.ram_wren, 1);
    chk("par_wraddr", bus.ram_wraddress, 32'h5);
    chk("par_rdaddr", bus.ram_rdaddress, 32'h5);
    step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00);
    chk("par_old_rvalid", bus.c1_rvalid, 1);
    chk("par_old_c0_rvalid", bus.c0_rvalid, 0);
    chk("par_old_rdata", bus.c1_rdata, 32'h00);
    chk("par_reread_gnt", bus.c1_gnt, 1);
    idle();
    chk("par_new_rvalid", bus.c1_rvalid, 1);
    chk("par_new_rdata", bus.c1_rdata, 32'h11);

    // contested reads: c0 addr 3 (0x55), c1 addr 5 (0x11)
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00);
      chk("cr_c0_gnt", bus.c0_gnt, (k % 2 == 0) ? 1 : 0);
      chk("cr_c1_gnt", bus.c1_gnt, (k % 2 == 1) ? 1 : 0);
      if (k == 0) begin
        chk("cr_c0_rvalid", bus.c0_rvalid, 0);
        chk("cr_c1_rvalid", bus.c1_rvalid, 0);
      end else begin
        chk("cr_c0_rvalid", bus.c0_rvalid, (k % 2 == 1) ? 1 : 0);
        chk("cr_c1_rvalid", bus.c1_rvalid, (k % 2 == 0) ? 1 : 0);
        chk("cr_rdata", bus.c0_rdata, (k % 2 == 1) ? 32'h55 : 32'h11);
      end
    end
    idle();
    chk("cr_last_c1_rvalid", bus.c1_rvalid, 1);
    chk("cr_last_c0_rvalid", bus.c0_rvalid, 0);
    chk("cr_last_rdata", bus.c1_rdata, 32'h11);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'(i), 8'(8'h30 + i), 1'b0, 1'b0, 4'h0, 8'h00);
      chk("fill_c0_gnt", bus.c0_gnt, 1);
    end

    // uncontested back-to-back reads by c1
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'(k), 8'h00);
      chk("str_c1_gnt", bus.c1_gnt, 1);
      chk("str_c0_rvalid", bus.c0_rvalid, 0);
      if (k > 0) begin
        chk("str_c1_rvalid", bus.c1_rvalid, 1);
        chk("str_rdata", bus.c1_rdata, 32'(8'h30 + k - 1));
      end
    end
    idle();
    chk("str_end_rvalid", bus.c1_rvalid, 1);
    chk("str_end_rdata", bus.c1_rdata, 32'h3F);
    idle();
    chk("str_done_rvalid", bus.c1_rvalid, 0);

    // read granted, then reset in the next cycle
    step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("mr_c0_gnt", bus.c0_gnt, 1);
    step(1'b1, 1'b1, 1'b0, 4'h4, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("mr_rst_c0_gnt", bus.c0_gnt, 0);
    chk("mr_rst_wren", bus.ram_wren, 0);
    step(1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00);
    chk("mr_c0_rvalid", bus.c0_rvalid, 0);
    chk("mr_c1_rvalid", bus.c1_rvalid, 0);
    chk("mr_rdprio_c0_gnt", bus.c0_gnt, 1);
    chk("mr_rdprio_c1_gnt", bus.c1_gnt, 0);
    idle();
    chk("mr_after_rvalid", bus.c0_rvalid, 1);
    chk("mr_after_rdata", bus.c0_rdata, 32'h33);
    step(1'b0, 1'b1, 1'b1, 4'h7, 8'h77, 1'b1, 1'b1, 4'h8, 8'h88);
    chk("mr_wrprio_c0_gnt", bus.c0_gnt, 1);
    chk("mr_wrprio_c1_gnt", bus.c1_gnt, 0);
    chk("mr_wrprio_data", bus.ram_data, 32'h77);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-client arbiter that shares one simple dual-port RAM (one write port, one registered read port, 1-cycle read latency) between two requesters. The write port and the read port are arbitrated independently with per-port round-robin, so one write and one read can complete in the same cycle. Read data is returned with a per-client valid strobe. The block sits directly in front of the RAM instance; the RAM ports are driven only by this block.

## Interface

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width (depth 2**ADDR_WIDTH)

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- c0_req / c1_req  input  1  client access request
- c0_we / c1_we  input  1  1 = write, 0 = read; qualifies req
- c0_addr / c1_addr  input  ADDR_WIDTH  access address
- c0_wdata / c1_wdata  input  DATA_WIDTH  write data
- c0_gnt / c1_gnt  output  1  access accepted this cycle (combinational)
- c0_rvalid / c1_rvalid  output  1  read data valid this cycle (registered)
- c0_rdata / c1_rdata  output  DATA_WIDTH  read data, meaningful only with rvalid
- ram_wren  output  1  RAM write enable
- ram_wraddress  output  ADDR_WIDTH  RAM write address
- ram_data  output  DATA_WIDTH  RAM write data
- ram_rdaddress  output  ADDR_WIDTH  RAM read address
- ram_q  input  DATA_WIDTH  RAM registered read data

## Operation

- Handshake: transfer occurs in any cycle with cN_req && cN_gnt. Client holds req/we/addr/wdata stable until granted; it may drop req before grant (no transfer).
- Write port: candidates are clients with req && we. Read port: candidates are clients with req && !we.
- Per port: one candidate gets gnt. Two candidates: grant the client indicated by that port's priority pointer.
- Pointers: wr_prio and rd_prio, 1 bit each. After a contested or uncontested grant on a port, that pointer moves to the other client (last-granted gets low priority). No grant leaves the pointer unchanged.
- Granted write: ram_wren=1, ram_wraddress/ram_data from winner, same cycle. No write grant: ram_wren=0, address/data hold the last values (don't-care).
- Granted read: ram_rdaddress from winner in the same cycle. A registered 2-bit rd_owner records the winner. Next cycle, cN_rvalid=1 for that owner only.
- c0_rdata = c1_rdata = ram_q (shared bus), qualified by rvalid.
- Starvation bound: a held request is granted within 2 cycles of assertion.
- Same-address read and write granted in the same cycle: read returns the OLD word (RAM read-before-write). A write granted in cycle T is visible to a read granted in T+1 or later.

## Timing

- Reset (rst high at edge): wr_prio=rd_prio=0 (client 0 favoured), rvalid outputs 0. While rst is high, c0_gnt=c1_gnt=0 and ram_wren=0 regardless of requests.
- gnt and RAM address/control are combinational from req/we/pointers: zero-cycle grant.
- Read latency: grant in cycle T -> rvalid and ram_q valid in cycle T+1, for exactly one cycle.
- Back-to-back reads: a new read grant every cycle is allowed; rvalid is 1 every cycle following each grant.
- Reset mid-operation: a read granted in the cycle where rst is sampled high is not granted. rvalid is 0 in the cycle after reset regardless of prior grants. RAM contents are not cleared.

## Test plan

- Reset: hold rst 2 cycles with both clients requesting write -> gnt=0, ram_wren=0. After release, first contested write goes to c0.
- Contested writes: c0 writes addr 3 = 0xAA, c1 writes addr 3 = 0x55, both held -> c0 granted cycle 1, c1 cycle 2. Read addr 3 afterwards returns 0x55.
- Parallel ports: c0 writes addr 5 = 0x11 while c1 reads addr 5 (old value 0x00), same cycle -> both gnt=1, c1_rvalid next cycle with rdata 0x00. c1 re-reads -> 0x11.
- Contested reads, held 4 cycles -> grants alternate c0,c1,c0,c1. rvalid alternates one cycle later with correct data per address.
- Uncontested streaming: c1 reads addr 0..15 on consecutive cycles -> c1_rvalid high 16 consecutive cycles, data in order, c0_rvalid stays 0.
- Mid-read reset: c0 read granted at T, rst high at T+1 -> c0_rvalid=0 at T+2. rd_prio returns to 0.
